fixed_acc_arbiter: RTL

FIXED_ACC_ARBITER -- requirements
Module: fixed_acc_arbiter

---
 rtl/fixed_acc_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/fixed_acc_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fixed_acc_pkg.sv
// Shared types and default widths for the fixed-point accumulator arbiter
// and the accumulator it feeds.
package fixed_acc_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_IN_WIDTH  = 32;
  localparam int DEF_ACC_WIDTH = 128;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping to the lowest index when nothing at or above ptr is requesting.
module rr_arbiter
  import fixed_acc_pkg::*;
#(
  parameter int  N_REQ = DEF_N_REQ,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt
);

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] pick_masked;
  logic [N_REQ-1:0] pick_all;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign masked[gi] = req[gi] && (int'(ptr) <= gi);
    end
  endgenerate

  // x & -x isolates the lowest set bit
  assign pick_masked = masked & (~masked + N_REQ'(1));
  assign pick_all    = req & (~req + N_REQ'(1));
  assign gnt         = (|masked) ? pick_masked : pick_all;

endmodule

// File: rtl/fixed_acc_arbiter.sv
// Round-robin front end that streams one requester's vector at a time into
// an external fixed-point accumulator and returns the sum on a result channel.
module fixed_acc_arbiter
  import fixed_acc_pkg::*;
#(
  parameter int  N_REQ     = DEF_N_REQ,
  parameter int  IN_WIDTH  = DEF_IN_WIDTH,
  parameter int  ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int  CNT_WIDTH = DEF_CNT_WIDTH,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ*IN_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [IN_WIDTH-1:0]       acc_a,
  output logic                      acc_nd,
  output logic                      acc_done,
  input  logic [ACC_WIDTH-1:0]      acc_in,
  output logic [ACC_WIDTH-1:0]      res_data,
  output logic [ID_W-1:0]           res_id,
  output logic [CNT_WIDTH-1:0]      res_cnt,
  output logic                      res_valid,
  input  logic                      res_ready
);

  state_t               state_reg, state_next;
  logic [ID_W-1:0]      grant_reg, grant_next;
  logic [ID_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [ACC_WIDTH-1:0] res_data_reg;
  logic [ID_W-1:0]      res_id_reg;
  logic [CNT_WIDTH-1:0] res_cnt_reg;

  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic             accept;
  logic             done_int;
  logic             load_res;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_reg),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = ID_W'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == ST_STREAM) && (grant_reg == ID_W'(gi));
    end
  endgenerate

  assign accept = (state_reg == ST_STREAM) && req_valid[grant_reg];
  assign acc_a  = accept ? req_data[grant_reg*IN_WIDTH +: IN_WIDTH] : '0;
  assign acc_nd = accept;
  // Reset must silence the CLEAR pulse immediately, not at the next edge
  assign acc_done  = done_int && rst_n;
  assign res_valid = (state_reg == ST_RESULT);
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign res_cnt   = res_cnt_reg;

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    cnt_next    = cnt_reg;
    done_int    = 1'b0;
    load_res    = 1'b0;
    unique case (state_reg)
      ST_CLEAR: begin
        done_int   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (|req_valid) begin
          grant_next = arb_idx;
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept) begin
          cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_WIDTH'(1);
          if (req_last[grant_reg]) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        load_res   = 1'b1;
        state_next = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready) begin
          done_int    = 1'b1;
          rr_ptr_next = (grant_reg == ID_W'(N_REQ - 1)) ? '0 : grant_reg + ID_W'(1);
          cnt_next    = '0;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_CLEAR;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      cnt_reg      <= '0;
      res_data_reg <= '0;
      res_id_reg   <= '0;
      res_cnt_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      cnt_reg    <= cnt_next;
      if (load_res) begin
        res_data_reg <= acc_in;
        res_id_reg   <= grant_reg;
        res_cnt_reg  <= cnt_reg;
      end
    end
  end

endmodule
